// File: rtl/dla_acl_reset_sequencer.sv
// Reset sequencer feeding the dla_acl_fanout_pipeline: async assert, synchronized release,
// programmable hold, optional four-phase soft reset (enabled by DLA_RESET_SEQ_SOFT_REQ_EN).
module dla_acl_reset_sequencer #(
    parameter int SYNC_DEPTH  = 3,
    parameter int HOLD_CYCLES = 16
) (
    input  logic clk,
    input  logic areset,
    input  logic soft_req,
    output logic sclr,
    output logic ready,
    output logic soft_ack
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

`ifdef DLA_RESET_SEQ_SOFT_REQ_EN
    localparam logic SOFT_EN = 1'b1;
`else
    localparam logic SOFT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    logic [SYNC_DEPTH-1:0] sync_r;
    logic                  sync_out_s;
    state_t                state_r, state_nxt_s;
    logic [CW-1:0]         cnt_r, cnt_nxt_s;
    logic                  sclr_r, sclr_nxt_s;
    logic                  ready_r, ready_nxt_s;
    logic                  ack_r, ack_nxt_s;
    logic                  soft_hold_r, soft_hold_nxt_s;

    assign sync_out_s = sync_r[SYNC_DEPTH-1];
    assign sclr       = sclr_r;
    assign ready      = ready_r;
    assign soft_ack   = ack_r;

    // Deassertion synchronizer: clears asynchronously, shifts in ones once areset drops
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sync_r <= {SYNC_DEPTH{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_DEPTH-2:0], 1'b1};
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_r     <= ST_ASSERT;
            cnt_r       <= CNT_ZERO;
            sclr_r      <= 1'b1;
            ready_r     <= 1'b0;
            ack_r       <= 1'b0;
            soft_hold_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            sclr_r      <= sclr_nxt_s;
            ready_r     <= ready_nxt_s;
            ack_r       <= ack_nxt_s;
            soft_hold_r <= soft_hold_nxt_s;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        sclr_nxt_s      = sclr_r;
        ready_nxt_s     = ready_r;
        ack_nxt_s       = ack_r;
        soft_hold_nxt_s = soft_hold_r;
        case (state_r)
            ST_ASSERT: begin
                sclr_nxt_s  = 1'b1;
                ready_nxt_s = 1'b0;
                ack_nxt_s   = 1'b0;
                if (sync_out_s) begin
                    state_nxt_s     = ST_HOLD;
                    cnt_nxt_s       = CNT_ZERO;
                    soft_hold_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_ASSERT;
                end
            end
            ST_HOLD: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_RUN;
                    sclr_nxt_s  = 1'b0;
                    ready_nxt_s = 1'b1;
                    ack_nxt_s   = soft_hold_r;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_RUN: begin
                // While acknowledged, only the release of soft_req matters
                if (ack_r) begin
                    if (!soft_req) begin
                        ack_nxt_s = 1'b0;
                    end else begin
                        ack_nxt_s = 1'b1;
                    end
                end else if (soft_req && SOFT_EN) begin
                    state_nxt_s     = ST_HOLD;
                    cnt_nxt_s       = CNT_ZERO;
                    sclr_nxt_s      = 1'b1;
                    ready_nxt_s     = 1'b0;
                    soft_hold_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s     = ST_ASSERT;
                cnt_nxt_s       = CNT_ZERO;
                sclr_nxt_s      = 1'b1;
                ready_nxt_s     = 1'b0;
                ack_nxt_s       = 1'b0;
                soft_hold_nxt_s = 1'b0;
            end
        endcase
    end

endmodule
